// File: rtl/ex_stage_pkg.sv
// Shared widths, branch-kind encoding and the forwarded beat layout for the EX/MEM stage.
package ex_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 6;
    localparam int unsigned PC_W   = 32;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_Z    = 2'd1,
        BR_N    = 2'd2,
        BR_J    = 2'd3
    } br_kind_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
    } beat_t;

    // jmp dominates; a beat with both br_z and br_n classifies as BR_Z but
    // the condition evaluation still honours both flags.
    function automatic br_kind_e br_kind(input logic br_z, input logic br_n, input logic jmp);
        if (jmp)       return BR_J;
        else if (br_z) return BR_Z;
        else if (br_n) return BR_N;
        else           return BR_NONE;
    endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// Upstream/downstream handshake and flag/branch bus of the EX/MEM stage.
interface ex_mem_flag_stage_if #(
    parameter int unsigned DATA_W = ex_stage_pkg::DATA_W,
    parameter int unsigned RD_W   = ex_stage_pkg::RD_W,
    parameter int unsigned PC_W   = ex_stage_pkg::PC_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_out;
    logic              alu_z;
    logic              alu_n;
    logic              flag_we;
    logic [RD_W-1:0]   rd;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              br_z;
    logic              br_n;
    logic              jmp;
    logic [PC_W-1:0]   br_target;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_wr;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              flag_z;
    logic              flag_n;
    logic              take_branch;
    logic [PC_W-1:0]   branch_pc;

    modport master (
        output in_valid, alu_out, alu_z, alu_n, flag_we, rd, reg_wr, mem_rd, mem_wr,
               br_z, br_n, jmp, br_target, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_reg_wr, out_mem_rd, out_mem_wr,
               flag_z, flag_n, take_branch, branch_pc
    );

    modport slave (
        input  in_valid, alu_out, alu_z, alu_n, flag_we, rd, reg_wr, mem_rd, mem_wr,
               br_z, br_n, jmp, br_target, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_reg_wr, out_mem_rd, out_mem_wr,
               flag_z, flag_n, take_branch, branch_pc
    );

endinterface

// File: rtl/ex_mem_flag_stage_flag_reg.sv
// Architectural Z/N flag register with write enable and asynchronous clear.
module flag_reg (
    input  logic clk,
    input  logic reset,
    input  logic we,
    input  logic z_d,
    input  logic n_d,
    output logic z_q,
    output logic n_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (we) begin
            z_q <= z_d;
            n_q <= n_d;
        end
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register: captures ALU result, owns Z/N flags, resolves branches.
// Define EX_BRANCH_CNT_EN to add the br_taken_cnt taken-branch counter output.
module ex_mem_flag_stage #(
    parameter int unsigned DATA_W = ex_stage_pkg::DATA_W,
    parameter int unsigned RD_W   = ex_stage_pkg::RD_W,
    parameter int unsigned PC_W   = ex_stage_pkg::PC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_mem_flag_stage_if.slave   bus
`ifdef EX_BRANCH_CNT_EN
    ,
    output logic [31:0]          br_taken_cnt
`endif
);
    import ex_stage_pkg::*;

    br_kind_e kind;
    logic     is_branch;
    logic     cond;
    logic     accept;
    logic     take_next;
    logic     fz;
    logic     fn;

    assign kind      = br_kind(bus.br_z, bus.br_n, bus.jmp);
    assign is_branch = (kind != BR_NONE);
    // Condition uses the flags as stored before this edge.
    assign cond      = (kind == BR_J) | (bus.br_z & fz) | (bus.br_n & fn);

    // Stall while the downstream holds a beat, and squash the wrong-path beat during a redirect.
    assign bus.in_ready = (~bus.out_valid | bus.out_ready) & ~bus.take_branch;
    assign accept       = bus.in_valid & bus.in_ready;
    assign take_next    = accept & is_branch & cond;

    flag_reg u_flag_reg (
        .clk   (clk),
        .reset (reset),
        .we    (accept & ~is_branch & bus.flag_we),
        .z_d   (bus.alu_z),
        .n_d   (bus.alu_n),
        .z_q   (fz),
        .n_q   (fn)
    );

    assign bus.flag_z = fz;
    assign bus.flag_n = fn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_rd      <= '0;
            bus.out_reg_wr  <= 1'b0;
            bus.out_mem_rd  <= 1'b0;
            bus.out_mem_wr  <= 1'b0;
            bus.take_branch <= 1'b0;
            bus.branch_pc   <= '0;
        end else begin
            bus.take_branch <= take_next;
            if (take_next) begin
                bus.branch_pc <= bus.br_target;
            end
            // Branch beats never load the payload; they leave a bubble downstream.
            if (accept && !is_branch) begin
                bus.out_valid  <= 1'b1;
                bus.out_data   <= bus.alu_out;
                bus.out_rd     <= bus.rd;
                bus.out_reg_wr <= bus.reg_wr;
                bus.out_mem_rd <= bus.mem_rd;
                bus.out_mem_wr <= bus.mem_wr;
            end else if (bus.out_ready) begin
                bus.out_valid  <= 1'b0;
            end
        end
    end

`ifdef EX_BRANCH_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_taken_cnt <= '0;
        end else if (take_next) begin
            br_taken_cnt <= br_taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage with a scoreboard of forwarded beats.
module tb_ex_mem_flag_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    ex_mem_flag_stage_if #(.DATA_W(32), .RD_W(6), .PC_W(32)) bus ();

`ifdef EX_BRANCH_CNT_EN
    logic [31:0] br_taken_cnt;
`endif

    ex_mem_flag_stage #(.DATA_W(32), .RD_W(6), .PC_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef EX_BRANCH_CNT_EN
        ,
        .br_taken_cnt (br_taken_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.alu_out   = '0;
        bus.alu_z     = 1'b0;
        bus.alu_n     = 1'b0;
        bus.flag_we   = 1'b0;
        bus.rd        = '0;
        bus.reg_wr    = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.br_z      = 1'b0;
        bus.br_n      = 1'b0;
        bus.jmp       = 1'b0;
        bus.br_target = '0;
    endtask

    task automatic send(input logic [31:0] data, input logic [5:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic fwe, input logic z, input logic n);
        idle();
        bus.in_valid = 1'b1;
        bus.alu_out  = data;
        bus.rd       = rd;
        bus.reg_wr   = rw;
        bus.mem_rd   = mr;
        bus.mem_wr   = mw;
        bus.flag_we  = fwe;
        bus.alu_z    = z;
        bus.alu_n    = n;
    endtask

    task automatic send_br(input logic bz, input logic bn, input logic j, input logic [31:0] tgt,
                           input logic fwe, input logic z, input logic n);
        idle();
        bus.in_valid  = 1'b1;
        bus.alu_out   = 32'h0000_0BAD;
        bus.br_z      = bz;
        bus.br_n      = bn;
        bus.jmp       = j;
        bus.br_target = tgt;
        bus.flag_we   = fwe;
        bus.alu_z     = z;
        bus.alu_n     = n;
    endtask

    // Compare any beat leaving this cycle, record any non-branch beat entering, then advance.
    task automatic tick();
        beat_t eb;
        if (bus.out_valid && bus.out_ready) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL sb_underflow: observed out beat 0x%0h expected none", bus.out_data);
            end
            if (sb.size() > 0) begin
                eb = sb.pop_front();
                chk("sb_data", 64'(bus.out_data), 64'(eb.data));
                chk("sb_rd", 64'(bus.out_rd), 64'(eb.rd));
                chk("sb_ctl", 64'({bus.out_reg_wr, bus.out_mem_rd, bus.out_mem_wr}),
                    64'({eb.reg_wr, eb.mem_rd, eb.mem_wr}));
            end
        end
        if (bus.in_valid && bus.in_ready && !(bus.br_z || bus.br_n || bus.jmp)) begin
            eb.data   = bus.alu_out;
            eb.rd     = bus.rd;
            eb.reg_wr = bus.reg_wr;
            eb.mem_rd = bus.mem_rd;
            eb.mem_wr = bus.mem_wr;
            sb.push_back(eb);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_take_branch", 64'(bus.take_branch), 64'd0);
        chk("rst_flags", 64'({bus.flag_z, bus.flag_n}), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        reset = 1'b0;

        // Reset arriving while a beat is held downstream
        bus.out_ready = 1'b0;
        send(32'h11, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        chk("pre_rst_flags", 64'({bus.flag_z, bus.flag_n}), 64'b11);
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_flags", 64'({bus.flag_z, bus.flag_n}), 64'd0);
        chk("midrst_take_branch", 64'(bus.take_branch), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        #1 reset = 1'b0;

        // Basic one-cycle latency
        bus.out_ready = 1'b1;
        send(32'h0000_002A, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_out_data", 64'(bus.out_data), 64'h2A);
        chk("lat_out_rd", 64'(bus.out_rd), 64'd5);
        tick();
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure for three cycles with the next beat waiting
        bus.out_ready = 1'b0;
        send(32'h33, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        send(32'h44, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_data", 64'(bus.out_data), 64'h33);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        idle();
        chk("bp_next_data", 64'(bus.out_data), 64'h44);
        chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
        tick();

        // Z set, then taken br_z; its own flag_we must be ignored
        send(32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        send_br(1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b1);
        tick();
        send(32'hDEAD, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("brz_take", 64'(bus.take_branch), 64'd1);
        chk("brz_pc", 64'(bus.branch_pc), 64'h100);
        chk("brz_bubble", 64'(bus.out_valid), 64'd0);
        chk("brz_in_ready", 64'(bus.in_ready), 64'd0);
        chk("brz_flags_held", 64'({bus.flag_z, bus.flag_n}), 64'b10);
        tick();
        idle();
        chk("brz_pulse_end", 64'(bus.take_branch), 64'd0);
        chk("brz_wrong_path", 64'(bus.out_valid), 64'd0);

        // N clear: br_n not taken; jmp with br_z taken regardless
        send(32'h5, 6'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        send_br(1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        chk("brn_not_taken", 64'(bus.take_branch), 64'd0);
        chk("brn_bubble", 64'(bus.out_valid), 64'd0);
        send_br(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("jmp_take", 64'(bus.take_branch), 64'd1);
        chk("jmp_pc", 64'(bus.branch_pc), 64'h300);
        tick();
        chk("jmp_pulse_end", 64'(bus.take_branch), 64'd0);

        // Back-to-back beats (load+store forwarded as-is), then taken br_n
        send(32'hA0, 6'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        send(32'hB0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("b2b_out_data", 64'(bus.out_data), 64'hB0);
        send_br(1'b0, 1'b1, 1'b0, 32'h400, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("brn_take", 64'(bus.take_branch), 64'd1);
        chk("brn_pc", 64'(bus.branch_pc), 64'h400);
        tick();

`ifdef EX_BRANCH_CNT_EN
        chk("cnt_three", 64'(br_taken_cnt), 64'd3);
        force dut.br_taken_cnt = 32'hFFFF_FFFF;
        #1 release dut.br_taken_cnt;
        send_br(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("cnt_wrap", 64'(br_taken_cnt), 64'd0);
        chk("cnt_wrap_take", 64'(bus.take_branch), 64'd1);
        tick();
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
